// File: rtl/riscv_i32_pkg.sv
// ============================================================================
// Package : riscv_i32_pkg
// Shared RISC-V I32 front-end types: fetch-data beat and debug-op encoding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package riscv_i32_pkg;

  typedef enum logic [1:0] {
    DBG_OP_NONE   = 2'd0,
    DBG_OP_HALT   = 2'd1,
    DBG_OP_EXEC   = 2'd2,
    DBG_OP_RESUME = 2'd3
  } t_debug_op;

  typedef struct packed {
    logic        valid;
    t_debug_op   debug_op;
    logic [15:0] data;
  } t_debug;

  typedef struct packed {
    logic [31:0] data;
    t_debug      debug;
  } t_instruction;

  // The beat valid bit is not part of the stored payload; occupancy implies it.
  typedef struct packed {
    logic [2:0]   mode;
    logic [31:0]  pc;
    t_instruction instruction;
    logic         dec_predicted_branch;
    logic [31:0]  dec_pc_if_mispredicted;
  } t_fetch_data;

endpackage

`default_nettype wire

// File: rtl/riscv_i32_fetch_decode_buffer.sv
// ============================================================================
// Module : riscv_i32_fetch_decode_buffer
// Registered in-order queue of fetch beats feeding decode, with flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module riscv_i32_fetch_decode_buffer
  import riscv_i32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,

  input  logic                 pipeline_fetch_data__valid,
  input  logic [2:0]           pipeline_fetch_data__mode,
  input  logic [31:0]          pipeline_fetch_data__pc,
  input  logic [31:0]          pipeline_fetch_data__instruction__data,
  input  logic                 pipeline_fetch_data__instruction__debug__valid,
  input  logic [1:0]           pipeline_fetch_data__instruction__debug__debug_op,
  input  logic [15:0]          pipeline_fetch_data__instruction__debug__data,
  input  logic                 pipeline_fetch_data__dec_predicted_branch,
  input  logic [31:0]          pipeline_fetch_data__dec_pc_if_mispredicted,
  output logic                 fetch_ready,

  input  logic                 decode_ready,
  output logic                 decode_data__valid,
  output logic [2:0]           decode_data__mode,
  output logic [31:0]          decode_data__pc,
  output logic [31:0]          decode_data__instruction__data,
  output logic                 decode_data__instruction__debug__valid,
  output logic [1:0]           decode_data__instruction__debug__debug_op,
  output logic [15:0]          decode_data__instruction__debug__data,
  output logic                 decode_data__dec_predicted_branch,
  output logic [31:0]          decode_data__dec_pc_if_mispredicted,

  output logic [PTR_W:0]       occupancy
);

  localparam logic [PTR_W:0]   c_depth   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

  t_fetch_data          r_storage [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W:0]       r_count;

  t_fetch_data          w_in;
  t_fetch_data          w_head;
  logic                 w_not_empty;
  logic                 w_push;
  logic                 w_pop;

  always_comb begin
    w_in                                = '0;
    w_in.mode                           = pipeline_fetch_data__mode;
    w_in.pc                             = pipeline_fetch_data__pc;
    w_in.instruction.data               = pipeline_fetch_data__instruction__data;
    w_in.instruction.debug.valid        = pipeline_fetch_data__instruction__debug__valid;
    w_in.instruction.debug.debug_op     = t_debug_op'(pipeline_fetch_data__instruction__debug__debug_op);
    w_in.instruction.debug.data         = pipeline_fetch_data__instruction__debug__data;
    w_in.dec_predicted_branch           = pipeline_fetch_data__dec_predicted_branch;
    w_in.dec_pc_if_mispredicted         = pipeline_fetch_data__dec_pc_if_mispredicted;
  end

  // fetch_ready depends on registered count only, so no decode_ready -> fetch path.
  assign w_not_empty = (r_count != '0);
  assign fetch_ready = (r_count != c_depth);
  assign w_push      = pipeline_fetch_data__valid & fetch_ready & ~flush;
  assign w_pop       = w_not_empty & decode_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload registers are deliberately unreset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_storage[r_wr_ptr] <= w_in;
    end
  end

  always_comb begin
    w_head = '0;
    if (w_not_empty) begin
      w_head = r_storage[r_rd_ptr];
    end
  end

  assign decode_data__valid                        = w_not_empty;
  assign decode_data__mode                         = w_head.mode;
  assign decode_data__pc                           = w_head.pc;
  assign decode_data__instruction__data            = w_head.instruction.data;
  assign decode_data__instruction__debug__valid    = w_head.instruction.debug.valid;
  assign decode_data__instruction__debug__debug_op = w_head.instruction.debug.debug_op;
  assign decode_data__instruction__debug__data     = w_head.instruction.debug.data;
  assign decode_data__dec_predicted_branch         = w_head.dec_predicted_branch;
  assign decode_data__dec_pc_if_mispredicted       = w_head.dec_pc_if_mispredicted;
  assign occupancy                                 = r_count;

endmodule

`default_nettype wire

// File: tb/tb_riscv_i32_fetch_decode_buffer.sv
// ============================================================================
// Module : tb_riscv_i32_fetch_decode_buffer
// Directed self-checking bench for the fetch-to-decode buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_i32_fetch_decode_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_mode;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic        in_dbg_valid;
  logic [1:0]  in_dbg_op;
  logic [15:0] in_dbg_data;
  logic        in_pred;
  logic [31:0] in_mpc;
  logic        fetch_ready;
  logic        decode_ready;
  logic        out_valid;
  logic [2:0]  out_mode;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic        out_dbg_valid;
  logic [1:0]  out_dbg_op;
  logic [15:0] out_dbg_data;
  logic        out_pred;
  logic [31:0] out_mpc;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  riscv_i32_fetch_decode_buffer #(.DEPTH(2), .PTR_W(1)) dut (
    .clk                                              (clk),
    .reset                                            (reset),
    .flush                                            (flush),
    .pipeline_fetch_data__valid                       (in_valid),
    .pipeline_fetch_data__mode                        (in_mode),
    .pipeline_fetch_data__pc                          (in_pc),
    .pipeline_fetch_data__instruction__data           (in_data),
    .pipeline_fetch_data__instruction__debug__valid   (in_dbg_valid),
    .pipeline_fetch_data__instruction__debug__debug_op(in_dbg_op),
    .pipeline_fetch_data__instruction__debug__data    (in_dbg_data),
    .pipeline_fetch_data__dec_predicted_branch        (in_pred),
    .pipeline_fetch_data__dec_pc_if_mispredicted      (in_mpc),
    .fetch_ready                                      (fetch_ready),
    .decode_ready                                     (decode_ready),
    .decode_data__valid                               (out_valid),
    .decode_data__mode                                (out_mode),
    .decode_data__pc                                  (out_pc),
    .decode_data__instruction__data                   (out_data),
    .decode_data__instruction__debug__valid           (out_dbg_valid),
    .decode_data__instruction__debug__debug_op        (out_dbg_op),
    .decode_data__instruction__debug__data            (out_dbg_data),
    .decode_data__dec_predicted_branch                (out_pred),
    .decode_data__dec_pc_if_mispredicted              (out_mpc),
    .occupancy                                        (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] pc, input logic [31:0] data);
    in_valid     = 1'b1;
    in_mode      = 3'd0;
    in_pc        = pc;
    in_data      = data;
    in_dbg_valid = 1'b0;
    in_dbg_op    = 2'd0;
    in_dbg_data  = 16'h0;
    in_pred      = 1'b0;
    in_mpc       = 32'h0;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    idle_in();
    decode_ready = 1'b1;
    step();
    step();
    decode_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; decode_ready = 1'b0;
    beat(32'h0, 32'h0); idle_in();
    step(); step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready: got %0b want 1", fetch_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    checks++; if (out_pc !== 32'h0 || out_data !== 32'h0) begin errors++; $display("FAIL reset_fields: got pc=%h data=%h want 0", out_pc, out_data); end
  endtask

  task automatic test_single_push();
    beat(32'h100, 32'h0000_0013);
    step();
    idle_in();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL single_pc: got %h want 00000100", out_pc); end
    checks++; if (out_data !== 32'h13) begin errors++; $display("FAIL single_data: got %h want 00000013", out_data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    drain();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got occ=%0d valid=%0b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_fill_full();
    decode_ready = 1'b0;
    beat(32'h200, 32'hA); step();
    checks++; if (occupancy !== 2'd1 || fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_1: got occ=%0d rdy=%0b want 1/1", occupancy, fetch_ready); end
    beat(32'h204, 32'hB); step();
    checks++; if (occupancy !== 2'd2 || fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_2: got occ=%0d rdy=%0b want 2/0", occupancy, fetch_ready); end
    beat(32'h208, 32'hC); step();
    checks++; if (occupancy !== 2'd2 || out_pc !== 32'h200) begin errors++; $display("FAIL fill_held: got occ=%0d pc=%h want 2/00000200", occupancy, out_pc); end
    // Pop while full: third beat is still blocked this cycle.
    decode_ready = 1'b1; step();
    checks++; if (occupancy !== 2'd1 || out_pc !== 32'h204 || fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_pop: got occ=%0d pc=%h rdy=%0b want 1/00000204/1", occupancy, out_pc, fetch_ready); end
    step();
    idle_in();
    checks++; if (occupancy !== 2'd1 || out_pc !== 32'h208 || out_data !== 32'hC) begin errors++; $display("FAIL fill_third: got occ=%0d pc=%h data=%h want 1/00000208/0000000c", occupancy, out_pc, out_data); end
    drain();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fill_drain: got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_push_pop();
    decode_ready = 1'b0;
    beat(32'h100, 32'h13); step();
    beat(32'h104, 32'h93); decode_ready = 1'b1; step();
    idle_in(); decode_ready = 1'b0;
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL pushpop_occ: got %0d want 1", occupancy); end
    checks++; if (out_pc !== 32'h104 || out_data !== 32'h93) begin errors++; $display("FAIL pushpop_head: got pc=%h data=%h want 00000104/00000093", out_pc, out_data); end
    drain();
  endtask

  task automatic test_flush();
    decode_ready = 1'b0;
    beat(32'h300, 32'h1); step();
    beat(32'h304, 32'h2); step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre: got occ=%0d want 2", occupancy); end
    beat(32'h308, 32'h3); flush = 1'b1; decode_ready = 1'b1; step();
    flush = 1'b0; decode_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got valid=%0b occ=%0d rdy=%0b want 0/0/1", out_valid, occupancy, fetch_ready); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL flush_mask: got pc=%h want 0", out_pc); end
    // The beat presented on the flush cycle must be dropped, not captured.
    idle_in(); step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_drop: got occ=%0d want 0", occupancy); end
    beat(32'h30C, 32'h4); step(); idle_in();
    checks++; if (out_pc !== 32'h30C || occupancy !== 2'd1) begin errors++; $display("FAIL flush_after: got pc=%h occ=%0d want 0000030c/1", out_pc, occupancy); end
    drain();
  endtask

  task automatic test_debug();
    decode_ready = 1'b0;
    beat(32'h400, 32'h13); step();
    beat(32'h404, 32'h0);
    in_mode = 3'd3; in_dbg_valid = 1'b1; in_dbg_op = 2'd2; in_dbg_data = 16'hBEEF;
    in_pred = 1'b1; in_mpc = 32'h500;
    step(); idle_in();
    checks++; if (out_pc !== 32'h400 || out_dbg_valid !== 1'b0) begin errors++; $display("FAIL dbg_first: got pc=%h dbgv=%0b want 00000400/0", out_pc, out_dbg_valid); end
    decode_ready = 1'b1; step(); decode_ready = 1'b0;
    checks++; if (out_pc !== 32'h404 || out_dbg_valid !== 1'b1) begin errors++; $display("FAIL dbg_second: got pc=%h dbgv=%0b want 00000404/1", out_pc, out_dbg_valid); end
    checks++; if (out_dbg_op !== 2'd2 || out_dbg_data !== 16'hBEEF) begin errors++; $display("FAIL dbg_payload: got op=%0d data=%h want 2/beef", out_dbg_op, out_dbg_data); end
    checks++; if (out_mode !== 3'd3 || out_pred !== 1'b1 || out_mpc !== 32'h500) begin errors++; $display("FAIL dbg_side: got mode=%0d pred=%0b mpc=%h want 3/1/00000500", out_mode, out_pred, out_mpc); end
    drain();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL dbg_drain: got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    decode_ready = 1'b0;
    beat(32'h600, 32'h1); step();
    beat(32'h604, 32'h2); step();
    beat(32'h608, 32'h3); decode_ready = 1'b1; reset = 1'b1; step();
    reset = 1'b0; idle_in(); decode_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state: got valid=%0b occ=%0d rdy=%0b want 0/0/1", out_valid, occupancy, fetch_ready); end
    checks++; if (out_pc !== 32'h0 || out_dbg_data !== 16'h0 || out_mpc !== 32'h0) begin errors++; $display("FAIL rstmid_fields: got pc=%h dbg=%h mpc=%h want 0", out_pc, out_dbg_data, out_mpc); end
    // Pop on an empty buffer must leave it empty.
    decode_ready = 1'b1; step(); decode_ready = 1'b0;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop: got occ=%0d valid=%0b want 0/0", occupancy, out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_full();
    test_push_pop();
    test_flush();
    test_debug();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
